data_memory_sync: RTL and testbench
===================================

// Module: data_memory_sync
// PURPOSE
//  Clocked, byte-addressed LEGv8 data memory for the MEM stage; successor to the combinational data memory.
//  Supports byte/half/word/doubleword loads and stores with sign- or zero-extension.
//  Registered read (1-cycle latency) with a valid strobe; detects misaligned, out-of-range and conflicting requests.
//  Sits between the ALU result/store-data path and the writeback mux.
// PARAMETERS
//  DATA_WIDTH   64   data path width; fixed at 64, any other value is a $error at elaboration
//  ADDR_WIDTH   64   byte-address width
//  DEPTH        128  number of 64-bit doublewords; power of two, >= 2
//  INIT_PATTERN 1    1: doubleword i preloaded with value i at time zero; 0: all zero
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      asynchronous active-low reset
//  memRead       in   1      load request this cycle
//  memWrite      in   1      store request this cycle
//  accessSize    in   2      00 byte, 01 half, 10 word, 11 doubleword
//  signExtend    in   1      loads only: 1 sign-extend, 0 zero-extend (ignored for doubleword)
//  inputAddress  in   64     byte address
//  inputData     in   64     store data, right-aligned (low bytes used)
//  outputData    out  64     load result, registered
//  readValid     out  1      1-cycle pulse: outputData holds the result of the load issued last cycle
//  fault         out  1      1-cycle pulse: the request issued last cycle was rejected
//  faultCode     out  2      01 misaligned, 10 out of range, 11 read+write conflict; held until next fault
// BEHAVIOUR
//  - Reset (async assert, sync release): outputData=0, readValid=0, fault=0, faultCode=00; RAM contents unchanged.
//  - Address decode: doubleword index = inputAddress[$clog2(DEPTH)+2:3]; byte lane = inputAddress[2:0].
//  - Alignment: half needs addr[0]=0; word needs addr[1:0]=0; dword needs addr[2:0]=0; byte always aligned.
//  - Range: any nonzero bit in inputAddress[ADDR_WIDTH-1:$clog2(DEPTH)+3] is out of range.
//  - Fault priority: conflict (memRead&memWrite) > out of range > misaligned. A faulted request does
//    not write the RAM, and readValid is not raised for it; next cycle fault=1, faultCode set, outputData=0.
//  - Store: on the clk edge, the lanes selected by size/lane are written with inputData's low bytes;
//    other lanes of that doubleword are untouched.
//  - Load: the lanes are extracted and shifted to bit 0, then extended per signExtend.
//    The result is registered: outputData and readValid=1 are valid in the cycle after the request.
//  - No request or faulted request: readValid=0 next cycle; outputData keeps its last value (0 after a fault).
//  - Back-to-back: one request per cycle, no stalls. A load immediately after a store to the same
//    address returns the new data, because the store commits on the edge before the load is sampled.
//  - Reset asserted mid-operation: the request in flight is dropped. A store on the same edge as the
//    reset assertion is not guaranteed to commit.
// CONFIGURATION
//  DMEM_STATS_EN defined: adds outputs statReads, statWrites, statFaults (each 32-bit). Each counts
//    accepted loads, accepted stores and faults respectively, saturating at 32'hFFFF_FFFF.
//    All three counters clear on reset.
//  Not defined: those ports and counters are absent; all other behaviour is identical.
// TESTING
//  1 Reset, INIT_PATTERN=1: dword load at addr 0x40 -> next cycle readValid=1, outputData=8.
//  2 Store dword 0xFFEE_DDCC_BBAA_9988 @0x10, then load byte @0x17 with signExtend=1 ->
//    0xFFFF_FFFF_FFFF_FFFF; same load with signExtend=0 -> 0x0000_0000_0000_00FF.
//  3 Store half 0x1234 @0x22, then load dword @0x20 -> 0x0000_0000_1234_0004; other bytes intact.
//  4 Load word @0x0A -> fault=1, faultCode=01, readValid=0; a store at the same address leaves the RAM unchanged.
//  5 Load @0x400 with DEPTH=128 -> faultCode=10. memRead=memWrite=1 @0x08 -> faultCode=11, no write.
//  6 Store/load alternated every cycle over 0x00-0x38 -> every load returns the preceding store's data.
//    rst_n pulsed mid-stream -> outputs zero immediately, RAM retains committed data.
//    With DMEM_STATS_EN, counters match the issued read/write/fault counts.

Source files
------------

// File: rtl/data_memory_sync_if.sv
// Request/response bundle between the MEM stage and data_memory_sync.
// master drives requests and consumes load results; slave is the memory.
interface data_memory_sync_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
);
    logic                  memRead;
    logic                  memWrite;
    logic [1:0]            accessSize;
    logic                  signExtend;
    logic [ADDR_WIDTH-1:0] inputAddress;
    logic [DATA_WIDTH-1:0] inputData;
    logic [DATA_WIDTH-1:0] outputData;
    logic                  readValid;
    logic                  fault;
    logic [1:0]            faultCode;

    modport master (
        output memRead, memWrite, accessSize, signExtend, inputAddress, inputData,
        input  outputData, readValid, fault, faultCode
    );

    modport slave (
        input  memRead, memWrite, accessSize, signExtend, inputAddress, inputData,
        output outputData, readValid, fault, faultCode
    );
endinterface

// File: rtl/data_memory_sync.sv
// Clocked byte-addressed LEGv8 data memory: registered loads, byte-lane stores, request fault detection.
// Optional statistics counters (statReads/statWrites/statFaults) are enabled by defining DMEM_STATS_EN.
module data_memory_sync #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 64,
    parameter int DEPTH        = 128,
    parameter int INIT_PATTERN = 1
) (
    input  logic clk,
    input  logic rst_n,
    data_memory_sync_if.slave bus
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] statReads,
    output logic [31:0] statWrites,
    output logic [31:0] statFaults
`endif
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    if (DATA_WIDTH != 64) begin : g_width_check
        $error("data_memory_sync: DATA_WIDTH must be 64");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("data_memory_sync: DEPTH must be a power of two >= 2");
    end

    typedef logic [63:0] mem_t [DEPTH];

    function automatic mem_t init_mem();
        mem_t m;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            m[i] = (INIT_PATTERN == 1) ? 64'(i) : '0;
        end
        return m;
    endfunction

    // Power-up contents only; reset never touches the array.
    mem_t mem = init_mem();

    logic [IDX_W-1:0] idx;
    logic [2:0]       lane;
    logic             out_of_range;
    logic             misaligned;
    logic             conflict;
    logic             fault_now;
    logic [1:0]       code_now;
    logic             accept_rd;
    logic             accept_wr;
    logic [7:0]       wmask;
    logic [63:0]      wdata;
    logic [63:0]      rword;
    logic [63:0]      load_val;

    assign idx          = bus.inputAddress[IDX_W+2:3];
    assign lane         = bus.inputAddress[2:0];
    assign out_of_range = |bus.inputAddress[ADDR_WIDTH-1:IDX_W+3];
    assign conflict     = bus.memRead & bus.memWrite;

    always_comb begin
        misaligned = 1'b0;
        wmask      = 8'h00;
        unique case (bus.accessSize)
            2'b00: begin misaligned = 1'b0;                        wmask = 8'h01 << lane; end
            2'b01: begin misaligned = bus.inputAddress[0];          wmask = 8'h03 << lane; end
            2'b10: begin misaligned = |bus.inputAddress[1:0];       wmask = 8'h0F << lane; end
            2'b11: begin misaligned = |bus.inputAddress[2:0];       wmask = 8'hFF;         end
        endcase
    end

    // Priority: conflict > out of range > misaligned.
    always_comb begin
        code_now = 2'b00;
        if (conflict)          code_now = 2'b11;
        else if (out_of_range) code_now = 2'b10;
        else if (misaligned)   code_now = 2'b01;
    end

    assign fault_now = (bus.memRead | bus.memWrite) & (code_now != 2'b00);
    assign accept_rd = bus.memRead  & ~fault_now;
    assign accept_wr = bus.memWrite & ~fault_now;

    assign wdata = bus.inputData << {lane, 3'b000};
    assign rword = mem[idx] >> {lane, 3'b000};

    always_comb begin
        load_val = rword;
        unique case (bus.accessSize)
            2'b00: load_val = bus.signExtend ? {{56{rword[7]}},  rword[7:0]}  : {56'd0, rword[7:0]};
            2'b01: load_val = bus.signExtend ? {{48{rword[15]}}, rword[15:0]} : {48'd0, rword[15:0]};
            2'b10: load_val = bus.signExtend ? {{32{rword[31]}}, rword[31:0]} : {32'd0, rword[31:0]};
            2'b11: load_val = rword;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept_wr && rst_n) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (wmask[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.outputData <= '0;
            bus.readValid  <= 1'b0;
            bus.fault      <= 1'b0;
            bus.faultCode  <= 2'b00;
        end else begin
            bus.readValid <= accept_rd;
            bus.fault     <= fault_now;
            if (fault_now) begin
                bus.faultCode  <= code_now;
                bus.outputData <= '0;
            end else if (accept_rd) begin
                bus.outputData <= load_val;
            end
        end
    end

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            statReads  <= '0;
            statWrites <= '0;
            statFaults <= '0;
        end else begin
            if (accept_rd && statReads  != '1) statReads  <= statReads  + 32'd1;
            if (accept_wr && statWrites != '1) statWrites <= statWrites + 32'd1;
            if (fault_now && statFaults != '1) statFaults <= statFaults + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_data_memory_sync.sv
// Randomized scoreboard bench for data_memory_sync against a byte-array reference memory.
module tb_data_memory_sync;
    localparam int DEPTH = 128;
    localparam int BYTES = DEPTH * 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    data_memory_sync_if #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) bus();

`ifdef DMEM_STATS_EN
    logic [31:0] stat_reads, stat_writes, stat_faults;
`endif

    data_memory_sync #(
        .DATA_WIDTH(64), .ADDR_WIDTH(64), .DEPTH(DEPTH), .INIT_PATTERN(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef DMEM_STATS_EN
        ,
        .statReads(stat_reads),
        .statWrites(stat_writes),
        .statFaults(stat_faults)
`endif
    );

    typedef struct {
        bit          is_fault;
        logic [1:0]  code;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model [BYTES];
    int vectors = 0, miscompares = 0, cyc = 0;
    int n_rd = 0, n_wr = 0, n_flt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop an expectation whenever the DUT presents a response.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (rst_n && (bus.readValid || bus.fault)) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_response: got valid=%0b fault=%0b expected none", bus.readValid, bus.fault);
            end else begin
                e = sb.pop_front();
                check("latency", 64'(cyc), 64'(e.cyc + 1));
                check("fault", 64'(bus.fault), 64'(e.is_fault));
                check("readValid", 64'(bus.readValid), 64'(!e.is_fault));
                if (e.is_fault) check("faultCode", 64'(bus.faultCode), 64'(e.code));
                check("outputData", bus.outputData, e.data);
            end
        end
    end

    task automatic drive_idle();
        bus.memRead = 1'b0; bus.memWrite = 1'b0; bus.accessSize = 2'b00;
        bus.signExtend = 1'b0; bus.inputAddress = '0; bus.inputData = '0;
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [1:0] size, input bit sext,
                         input logic [63:0] addr, input logic [63:0] data);
        exp_t e;
        int unsigned n;
        logic [63:0] val;
        @(negedge clk);
        bus.memRead = rd; bus.memWrite = wr; bus.accessSize = size;
        bus.signExtend = sext; bus.inputAddress = addr; bus.inputData = data;
        if (!(rd || wr)) return;
        n = 1 << size;
        e.cyc = cyc; e.data = '0; e.is_fault = 1'b1;
        if (rd && wr)                    e.code = 2'd3;
        else if (addr >= 64'(BYTES))     e.code = 2'd2;
        else if (addr % 64'(n) != 0)     e.code = 2'd1;
        else begin e.code = 2'd0; e.is_fault = 1'b0; end
        if (e.is_fault) begin
            n_flt++;
            sb.push_back(e);
        end else if (wr) begin
            n_wr++;
            for (int unsigned k = 0; k < n; k++) model[int'(addr) + k] = data[8*k +: 8];
        end else begin
            n_rd++;
            val = '0;
            for (int unsigned k = 0; k < n; k++) val |= 64'(model[int'(addr) + k]) << (8*k);
            if (sext && n < 8 && val[8*n-1]) val |= ~((64'd1 << (8*n)) - 64'd1);
            e.data = val;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        logic [63:0] a, d;
        int unsigned r, sz;
        for (int i = 0; i < DEPTH; i++)
            for (int b = 0; b < 8; b++) model[i*8 + b] = 8'((i >> (8*b)) & 8'hFF);
        drive_idle();

        #1 rst_n = 1'b0;
        #1;
        check("reset_outputData", bus.outputData, 64'd0);
        check("reset_readValid", 64'(bus.readValid), 64'd0);
        check("reset_fault", 64'(bus.fault), 64'd0);
        check("reset_faultCode", 64'(bus.faultCode), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        issue(1, 0, 2'b11, 0, 64'h40, 64'd0);
        issue(0, 1, 2'b11, 0, 64'h10, 64'hFFEE_DDCC_BBAA_9988);
        issue(1, 0, 2'b00, 1, 64'h17, 64'd0);
        issue(1, 0, 2'b00, 0, 64'h17, 64'd0);
        issue(0, 1, 2'b01, 0, 64'h22, 64'h1234);
        issue(1, 0, 2'b11, 0, 64'h20, 64'd0);
        issue(1, 0, 2'b10, 0, 64'h0A, 64'd0);
        issue(0, 1, 2'b10, 0, 64'h0A, 64'hDEAD_BEEF);
        issue(1, 0, 2'b11, 0, 64'h08, 64'd0);
        issue(1, 0, 2'b11, 0, 64'h400, 64'd0);
        issue(1, 1, 2'b11, 0, 64'h08, 64'hAAAA_5555);
        issue(1, 0, 2'b11, 0, 64'h08, 64'd0);
        idle();

        for (int i = 0; i < 8; i++) begin
            issue(0, 1, 2'b11, 0, 64'(i * 8), {$urandom, $urandom} | 64'h1);
            issue(1, 0, 2'b11, 0, 64'(i * 8), 64'd0);
        end

        // In-flight load aborted by reset: its response must never appear.
        issue(1, 0, 2'b11, 0, 64'h08, 64'd0);
        void'(sb.pop_back());
        n_rd--;
        #2 rst_n = 1'b0;
        #1;
        check("midreset_outputData", bus.outputData, 64'd0);
        check("midreset_readValid", 64'(bus.readValid), 64'd0);
        check("midreset_fault", 64'(bus.fault), 64'd0);
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        n_rd = 0; n_wr = 0; n_flt = 0;

        for (int i = 0; i < 8; i++) issue(1, 0, 2'b11, 0, 64'(i * 8), 64'd0);

        for (int i = 0; i < 400; i++) begin
            sz = $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            if (r == 0)      a = {$urandom, $urandom};
            else if (r == 1) a = 64'(BYTES + $urandom_range(0, 63));
            else begin
                a = 64'($urandom_range(0, BYTES - 8));
                if ($urandom_range(0, 3) != 0) a &= ~64'((1 << sz) - 1);
            end
            d = {$urandom, $urandom};
            r = $urandom_range(0, 9);
            if (r == 0)      issue(1, 1, 2'(sz), 1'($urandom), a, d);
            else if (r == 1) idle();
            else if (r < 6)  issue(0, 1, 2'(sz), 1'($urandom), a, d);
            else             issue(1, 0, 2'(sz), 1'($urandom), a, d);
        end

        for (int i = 0; i < DEPTH; i += 9) issue(1, 0, 2'b11, 0, 64'(i * 8), 64'd0);
        idle();
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
`ifdef DMEM_STATS_EN
        check("statReads", 64'(stat_reads), 64'(n_rd));
        check("statWrites", 64'(stat_writes), 64'(n_wr));
        check("statFaults", 64'(stat_faults), 64'(n_flt));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
